// File: rtl/alu_issue_unit_if.sv
// Bundle of all non-clock/reset signals of the ALU issue unit.
// The unit uses the slave view; the upstream/ALU/debug environment uses the master view.
interface alu_issue_unit_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport slave (
    input  instr_valid, instr, alu_result, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_control, wb_valid, wb_rd, wb_data, illegal, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_result, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_control, wb_valid, wb_rd, wb_data, illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Serial RV32I ALU issue unit: decodes one instruction, drives an external ALU for one
// cycle, then writes the result back into its 32-entry register file.
module alu_issue_unit (
  input logic             clk,
  input logic             rst_n,
  alu_issue_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] regs_q [32];
  logic [31:0] opA_q, opB_q, result_q;
  logic [2:0]  ctrl_q;
  logic [4:0]  rd_q;
  logic        illegal_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1Val, rs2Val, immI;
  logic        decLegal;
  logic [2:0]  decCtrl;
  logic [31:0] decOpB;
  logic        handshake;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign immI   = {{20{bus.instr[31]}}, bus.instr[31:20]};

  // x0 is never written, but reads are masked so it stays 0 regardless of storage.
  assign rs1Val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2Val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs_q[bus.dbg_addr];

  assign handshake   = bus.instr_valid && (state_q == IDLE);
  assign bus.illegal = illegal_q;

  always_comb begin
    decLegal = 1'b0;
    decCtrl  = ALU_ADD;
    decOpB   = 32'd0;
    if (opcode == 7'b0110011) begin
      decOpB   = rs2Val;
      decLegal = 1'b1;
      case ({funct7, funct3})
        {7'b0000000, 3'b000}: decCtrl = ALU_ADD;
        {7'b0100000, 3'b000}: decCtrl = ALU_SUB;
        {7'b0000000, 3'b001}: decCtrl = ALU_SLL;
        {7'b0000000, 3'b100}: decCtrl = ALU_XOR;
        {7'b0000000, 3'b110}: decCtrl = ALU_OR;
        {7'b0000000, 3'b111}: decCtrl = ALU_AND;
        default:              decLegal = 1'b0;
      endcase
    end else if (opcode == 7'b0010011) begin
      decOpB   = immI;
      decLegal = 1'b1;
      case (funct3)
        3'b000:  decCtrl = ALU_ADD;
        3'b100:  decCtrl = ALU_XOR;
        3'b110:  decCtrl = ALU_OR;
        3'b111:  decCtrl = ALU_AND;
        3'b001: begin
          decCtrl  = ALU_SLL;
          decOpB   = {27'd0, rs2};
          decLegal = (funct7 == 7'b0000000);
        end
        default: decLegal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= 32'd0;
      opB_q     <= 32'd0;
      ctrl_q    <= 3'd0;
      rd_q      <= 5'd0;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      illegal_q <= handshake && !decLegal;
      if (handshake && decLegal) begin
        opA_q  <= rs1Val;
        opB_q  <= decOpB;
        ctrl_q <= decCtrl;
        rd_q   <= bus.instr[11:7];
      end
      if (state_q == EXEC) begin
        result_q <= bus.alu_result;
      end
      if ((state_q == WB) && (rd_q != 5'd0)) begin
        regs_q[rd_q] <= result_q;
      end
    end
  end

  // Outputs are zero outside the state that owns them so the ALU and writeback ports idle cleanly.
  always_comb begin
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    bus.alu_a       = 32'd0;
    bus.alu_b       = 32'd0;
    bus.alu_control = 3'd0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 32'd0;
    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (handshake && decLegal) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        bus.alu_a       = opA_q;
        bus.alu_b       = opB_q;
        bus.alu_control = ctrl_q;
        state_d         = WB;
      end
      WB: begin
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd_q;
        bus.wb_data  = result_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: a driver issues directed and random instructions and
// queues expected results from a mnemonic-level model; a monitor checks every DUT response.
module tb_alu_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  alu_issue_unit_if bus ();

  alu_issue_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: purely combinational, as the unit expects.
  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_control)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b101:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      default: bus.alu_result = 32'd0;
    endcase
  end

  typedef struct {
    bit          illegalExp;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    int          cycle;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mregs[32];
  int          nChecks = 0;
  int          nFails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference semantics by mnemonic: what each instruction means, not how the unit decodes it.
  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    logic [31:0] v1, v2, imm;
    v1  = mregs[w[19:15]];
    v2  = mregs[w[24:20]];
    imm = {{20{w[31]}}, w[31:20]};
    e.illegalExp = 1'b0;
    e.rd = w[11:7];
    e.a = v1;
    e.b = v2;
    e.ctrl = 3'd0;
    e.data = 32'd0;
    e.cycle = 0;
    if (w[6:0] == 7'b0110011) begin
      case ({w[31:25], w[14:12]})
        {7'b0000000, 3'b000}: begin e.ctrl = 3'd0; e.data = v1 + v2; end
        {7'b0100000, 3'b000}: begin e.ctrl = 3'd1; e.data = v1 - v2; end
        {7'b0000000, 3'b001}: begin e.ctrl = 3'd5; e.data = v1 << v2[4:0]; end
        {7'b0000000, 3'b100}: begin e.ctrl = 3'd4; e.data = v1 ^ v2; end
        {7'b0000000, 3'b110}: begin e.ctrl = 3'd3; e.data = v1 | v2; end
        {7'b0000000, 3'b111}: begin e.ctrl = 3'd2; e.data = v1 & v2; end
        default:              e.illegalExp = 1'b1;
      endcase
    end else if (w[6:0] == 7'b0010011) begin
      e.b = imm;
      case (w[14:12])
        3'b000: begin e.ctrl = 3'd0; e.data = v1 + imm; end
        3'b100: begin e.ctrl = 3'd4; e.data = v1 ^ imm; end
        3'b110: begin e.ctrl = 3'd3; e.data = v1 | imm; end
        3'b111: begin e.ctrl = 3'd2; e.data = v1 & imm; end
        3'b001: begin
          e.illegalExp = (w[31:25] != 7'd0);
          e.ctrl = 3'd5;
          e.b = {27'd0, w[24:20]};
          e.data = v1 << w[24:20];
        end
        default: e.illegalExp = 1'b1;
      endcase
    end else begin
      e.illegalExp = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    int          k;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 31));
    imm = 12'($urandom);
    k   = $urandom_range(0, 14);
    case (k)
      0:  return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      1:  return {7'h20, rs2[2:0] == 3'd0 ? 5'd1 : {2'd0, rs2[2:0]}, rs1, 3'b000, rd, 7'h33};
      2:  return {7'h00, rs2, rs1, 3'b001, rd, 7'h33};
      3:  return {7'h00, rs2, rs1, 3'b100, rd, 7'h33};
      4:  return {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
      5:  return {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
      6:  return {imm, rs1, 3'b000, rd, 7'h13};
      7:  return {imm, rs1, 3'b100, rd, 7'h13};
      8:  return {imm, rs1, 3'b110, rd, 7'h13};
      9:  return {imm, rs1, 3'b111, rd, 7'h13};
      10: return {7'h00, rs2, rs1, 3'b001, rd, 7'h13};
      11: return {7'h20, rs2, rs1, 3'b001, rd, 7'h13};
      12: return {imm, rs1, 3'b010, rd, 7'h13};
      13: return {7'h00, rs2, rs1, 3'b010, rd, 7'h33};
      default: return {imm, rs1, 3'b010, rd, 7'h03};
    endcase
  endfunction

  // Called at a negedge; leaves instr_valid high and returns at the negedge after the handshake.
  task automatic applyStimulus(input logic [31:0] w, output int hsCyc);
    int   waitCnt;
    exp_t e;
    waitCnt = 0;
    hsCyc = -1;
    bus.instr = w;
    bus.instr_valid = 1'b1;
    while (bus.instr_ready !== 1'b1 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.instr_ready !== 1'b1) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL handshake timeout: instr_ready got %b required 1", bus.instr_ready);
    end else begin
      hsCyc = cyc;
      e = model(w);
      e.cycle = cyc + (e.illegalExp ? 1 : 2);
      if (!e.illegalExp && e.rd != 5'd0) mregs[e.rd] = e.data;
      expQ.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    bus.instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkDbg(input logic [4:0] addr, input logic [31:0] expv);
    bus.dbg_addr = addr;
    #1;
    checkOutput($sformatf("dbg x%0d", addr), bus.dbg_data, expv);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.instr_valid = 1'b0;
    while (expQ.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    expQ.delete();
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per wb_valid/illegal pulse and checks idle writeback outputs.
  initial begin : monitor
    exp_t        e;
    logic [31:0] pa, pb;
    logic [2:0]  pc;
    pa = 32'd0;
    pb = 32'd0;
    pc = 3'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wb_valid || bus.illegal) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected response: wb_valid=%b illegal=%b required none", bus.wb_valid, bus.illegal);
          end else begin
            e = expQ.pop_front();
            checkOutput("illegal flag", {31'd0, bus.illegal}, {31'd0, e.illegalExp});
            checkOutput("wb_valid flag", {31'd0, bus.wb_valid}, {31'd0, !e.illegalExp});
            checkOutput("response cycle", 32'(cyc), 32'(e.cycle));
            if (!e.illegalExp) begin
              checkOutput("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
              checkOutput("wb_data", bus.wb_data, e.data);
              checkOutput("exec alu_a", pa, e.a);
              checkOutput("exec alu_b", pb, e.b);
              checkOutput("exec alu_control", {29'd0, pc}, {29'd0, e.ctrl});
              checkOutput("ready low in WB", {31'd0, bus.instr_ready}, 32'd0);
            end else begin
              checkOutput("ready after illegal", {31'd0, bus.instr_ready}, 32'd1);
            end
          end
        end else begin
          checkOutput("idle wb_rd", {27'd0, bus.wb_rd}, 32'd0);
          checkOutput("idle wb_data", bus.wb_data, 32'd0);
        end
      end
      pa = bus.alu_a;
      pb = bus.alu_b;
      pc = bus.alu_control;
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int hs, prevHs;
    bus.instr_valid = 1'b0;
    bus.instr = 32'd0;
    bus.dbg_addr = 5'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.dbg_addr = 5'd1;
    checkOutput("reset instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("reset alu_a", bus.alu_a, 32'd0);
    checkOutput("reset alu_b", bus.alu_b, 32'd0);
    checkOutput("reset alu_control", {29'd0, bus.alu_control}, 32'd0);
    checkOutput("reset wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    checkOutput("reset illegal", {31'd0, bus.illegal}, 32'd0);
    checkOutput("reset dbg_data", bus.dbg_data, 32'd0);

    $display("[TB] directed sequence");
    applyStimulus(32'h00500093, hs);
    applyStimulus(32'hFFD00113, hs);
    drain();
    checkDbg(5'd1, 32'd5);
    checkDbg(5'd2, 32'hFFFFFFFD);
    @(negedge clk);
    applyStimulus(32'h402081B3, hs);
    applyStimulus(32'h01F09213, hs);
    applyStimulus(32'h00708013, hs);
    drain();
    checkDbg(5'd3, 32'd8);
    checkDbg(5'd4, 32'h80000000);
    checkDbg(5'd0, 32'd0);
    @(negedge clk);
    applyStimulus(32'h0000A083, hs);
    applyStimulus(32'h0010D093, hs);
    drain();
    checkDbg(5'd1, 32'd5);
    @(negedge clk);

    $display("[TB] back-to-back issue");
    prevHs = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus({12'($urandom), 5'd6, 3'b000, 5'd6, 7'h13}, hs);
      if (i > 0) checkOutput("b2b handshake spacing", 32'(hs - prevHs), 32'd3);
      prevHs = hs;
    end
    drain();
    checkDbg(5'd6, mregs[6]);
    @(negedge clk);

    $display("[TB] reset during EXEC");
    bus.instr = 32'h00900293;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    checkOutput("ready after abort", {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("no wb after abort", {31'd0, bus.wb_valid}, 32'd0);
    checkDbg(5'd5, 32'd0);
    checkDbg(5'd1, 32'd0);
    idleCycles(4);

    $display("[TB] random stimulus");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
      applyStimulus(randInstr(), hs);
    end
    drain();
    for (int r = 0; r < 8; r++) checkDbg(5'(r), mregs[r]);
    @(negedge clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameters: none; all widths are fixed (XLEN 32, 32 architectural registers, 3-bit ALU opcode).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 instr_valid  input  1  upstream offers an instruction.
REQ-005 instr  input  32  RV32I instruction word; sampled only on handshake.
REQ-006 instr_ready  output  1  unit can accept an instruction this cycle.
REQ-007 alu_a  output  32  operand A to the external ALU.
REQ-008 alu_b  output  32  operand B to the external ALU (rs2 value or sign-extended immediate).
REQ-009 alu_control  output  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL.
REQ-010 alu_result  input  32  combinational result returned by the external ALU.
REQ-011 wb_valid  output  1  one-cycle pulse: register write committed this cycle.
REQ-012 wb_rd  output  5  destination register of the committed write.
REQ-013 wb_data  output  32  data written.
REQ-014 illegal  output  1  one-cycle pulse: accepted instruction was unsupported.
REQ-015 dbg_addr  input  5  debug register-file read address.
REQ-016 dbg_data  output  32  combinational read of register dbg_addr (x0 reads 0).

Function
REQ-017 The unit SHALL implement FSM states IDLE, EXEC, WB; handshake occurs when instr_valid && instr_ready.
REQ-018 instr_ready SHALL be 1 only in IDLE; instr_valid without ready SHALL have no effect.
REQ-019 IDLE -> EXEC on handshake of a legal instruction; decoded rs1 value, operand B, alu_control and rd SHALL be registered on that edge.
REQ-020 IDLE -> IDLE on handshake of an illegal instruction, with illegal=1 in the following cycle and no register write.
REQ-021 In EXEC, alu_a/alu_b/alu_control SHALL present the registered decode; alu_result SHALL be captured at the end of EXEC; EXEC -> WB unconditionally.
REQ-022 In WB, wb_valid=1, wb_rd=rd, wb_data=captured result, the register file SHALL be written at the end of the cycle unless rd=0; WB -> IDLE.
REQ-023 Latency: handshake at cycle N, EXEC at N+1, wb_valid at N+2, next instr_ready at N+3; throughput one instruction per 3 cycles.
REQ-024 Opcode 0110011 (R-type) SHALL decode, funct7/funct3: 0000000/000 ADD, 0100000/000 SUB, 0000000/001 SLL, 0000000/100 XOR, 0000000/110 OR, 0000000/111 AND; operand B = x[rs2].
REQ-025 Opcode 0010011 (I-type) SHALL decode funct3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI with B = sign-extended instr[31:20]; funct3 001 SLLI only with instr[31:25]=0000000, B = zero-extended instr[24:20].
REQ-026 Every other opcode/funct combination (including SLTI, SRLI, loads, branches) SHALL be illegal.
REQ-027 x0 SHALL always read 0; a write to rd=0 SHALL still pulse wb_valid with wb_rd=0 but leave x0 at 0.
REQ-028 Register reads at decode SHALL observe all previously committed writes (no forwarding needed: serial execution).
REQ-029 Arithmetic SHALL be modulo 2^32 (performed externally; unit passes results unchanged).
REQ-030 Outside EXEC, alu_a/alu_b SHALL be 0 and alu_control 000; outside WB, wb_valid=0, wb_rd=0, wb_data=0.

Reset
REQ-031 While rst_n=0 at a clock edge: state <= IDLE, all 32 registers <= 0, captured result/decode registers <= 0, illegal <= 0.
REQ-032 Reset asserted in EXEC or WB SHALL abort the instruction with no register write and no wb_valid pulse after reset.
REQ-033 First cycle after reset release: instr_ready=1, all other outputs 0.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093) then ADDI x2,x0,-3 (0xFFD00113) -> wb_data 5 then 0xFFFFFFFD; dbg_addr=2 reads 0xFFFFFFFD.
REQ-035 SUB x3,x1,x2 (0x402081B3) with ALU model -> alu_control=001, alu_a=5, alu_b=0xFFFFFFFD, wb_rd=3, wb_data=8, wb_valid exactly 2 cycles after handshake.
REQ-036 SLLI x4,x1,31 (0x01F09213) -> alu_b=31, wb_data 0x80000000; ADDI x0,x1,7 -> wb_valid with wb_rd=0, dbg x0 still 0.
REQ-037 LW word 0x0000A083 and SRLI (0x0010D093) -> illegal pulse 1 cycle, no wb_valid, instr_ready back next cycle, x1 unchanged.
REQ-038 instr_valid held high continuously with back-to-back ADDIs -> one handshake per 3 cycles, instr_ready low in EXEC/WB, instructions neither dropped nor duplicated.
REQ-039 rst_n=0 during EXEC of ADDI x5,x0,9 -> no wb_valid, x5 reads 0, instr_ready=1 after release.
